led_mode_sequencer: RTL and testbench
=====================================

Name: led_mode_sequencer

Overview:
Controller that owns the 8-bit LED bank on the edugraphics board and schedules what drives it. Four display modes, selected via debounced push buttons. Inputs come from the board switches and buttons; the output drives led directly. Contains a tick prescaler, per-button debouncers, a mode FSM and a pattern register.

Parameters:
TICK_DIV, 25000000, clk cycles per display tick (minimum 2); prescaler width is $clog2(TICK_DIV).
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized cycles required to accept a button level change (minimum 1).

Ports:
clk  input  1  system clock, all logic rising-edge.
rst_n  input  1  asynchronous, active-low reset.
switch  input  8  board switches, asynchronous; 2-FF synchronized internally.
push_btn  input  4  active-high buttons, asynchronous; [0]=next mode, [1]=prev mode, [2]=pause toggle, [3]=load switch into pattern.
led  output  8  registered LED drive.
mode  output  2  current mode: 0=MIRROR, 1=COUNT, 2=SHIFT, 3=BLINK.
paused  output  1  registered pause flag.

Behaviour:
- Reset (async assert, sync release): mode=MIRROR, led=8'h00, paused=0, pattern=0, prescaler=0, blink phase=0, all synchronizer/debounce state=0.
- Synchronizers: switch and push_btn each pass through 2 flops. sw_s denotes the synchronized switch value.
- Debounce, per button: the counter resets whenever the synchronized input equals the debounced level. Otherwise it increments. When the counter reaches DEBOUNCE_CYCLES-1 while still differing, the debounced level flips and the counter clears.
- A 0->1 debounced transition produces a one-cycle press pulse. Releases generate nothing.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick is a 1-cycle pulse when the count equals TICK_DIV-1. The prescaler holds its count while paused.
- Mode FSM: next press moves mode+1 mod 4 (BLINK->MIRROR). prev press moves mode-1 mod 4 (MIRROR->BLINK). If next and prev pulse in the same cycle, there is no change.
- On any mode change, in the same edge:
  - prescaler=0, paused=0, blink phase=1.
  - Pattern init: COUNT=8'h00, SHIFT=8'h01, BLINK=sw_s, MIRROR keeps pattern unchanged.
- Pause press toggles paused, except in a cycle with a mode change, where the mode change wins and paused=0.
- Load press sets pattern=sw_s in COUNT, SHIFT and BLINK. It is ignored in MIRROR.
- Priority for pattern per cycle: mode change > load > tick update.
- Tick update (only when not paused):
  - COUNT: pattern+1 mod 256; 8'hFF wraps to 8'h00.
  - SHIFT: rotate left by 1; 8'h80 becomes 8'h01; pattern 0 stays 0.
  - BLINK: phase toggles.
- led register, updated every cycle:
  - MIRROR: sw_s. Total switch-to-led latency is 3 clk.
  - COUNT and SHIFT: pattern.
  - BLINK: phase ? pattern : 8'h00.
- led follows the updated pattern one cycle after the pattern register changes.
- Button latency: a clean press reaches its pulse 2+DEBOUNCE_CYCLES cycles after the input edge is sampled. Glitches shorter than DEBOUNCE_CYCLES synchronized cycles are rejected.
- Reset mid-operation: all state returns to reset values immediately, and led=0 while rst_n=0.
- No combinational path from any input to any output.

Test Plan (TICK_DIV=4, DEBOUNCE_CYCLES=3):
1. Reset, then sweep switch 0..255 holding each value 20 cycles -> mode=0; led equals switch 3 cycles after each change; led=0 during reset.
2. Clean push_btn[0] press held 10 cycles -> mode=1 exactly once. led then reads 00, 01, 02 at successive 4-cycle ticks; after 256 ticks it wraps from FF to 00.
3. 2-cycle glitch on push_btn[0] -> no mode change. Press [1] from MIRROR -> mode=3. Press [0] and [1] simultaneously -> mode unchanged.
4. SHIFT mode: led 01,02,...,80,01 on ticks. Press [2] -> paused=1 and led frozen for 40 cycles. Press [2] again -> rotation resumes from the frozen value.
5. BLINK with switch=8'hA5: led alternates A5/00 every 4 cycles. Set switch=8'h3C and press [3] -> led alternates 3C/00. Press [3] in MIRROR -> pattern unchanged.
6. Assert rst_n=0 mid-COUNT at led=8'h17 -> led=0 and mode=0 asynchronously, without waiting for a clk edge. After release -> MIRROR behaviour resumes within 3 cycles.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// LED bank controller: synchronizes switches and buttons, debounces the buttons,
// and runs a four-mode display sequencer (mirror, count, shift, blink) driven
// by a prescaled display tick. All outputs are registered.
module led_mode_sequencer #(
  parameter int unsigned TICK_DIV        = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] switch,
  input  logic [3:0] push_btn,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       paused
);

  localparam int unsigned PsW = $clog2(TICK_DIV);
  // A single-cycle debounce still needs a 1-bit counter to keep the logic uniform.
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(TICK_DIV - 1);
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ModeMirror = 2'd0,
    ModeCount  = 2'd1,
    ModeShift  = 2'd2,
    ModeBlink  = 2'd3
  } mode_e;

  // Button indices.
  localparam int unsigned BtnNext  = 0;
  localparam int unsigned BtnPrev  = 1;
  localparam int unsigned BtnPause = 2;
  localparam int unsigned BtnLoad  = 3;

  logic [7:0]            sw_meta_q, sw_s_q;
  logic [3:0]            btn_meta_q, btn_s_q;
  logic [3:0]            db_lvl_q, db_lvl_d;
  logic [3:0][DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [3:0]            press_q, press_d;
  mode_e                 mode_q, mode_d;
  logic [7:0]            pattern_q, pattern_d;
  logic [PsW-1:0]        ps_q, ps_d;
  logic                  paused_q, paused_d;
  logic                  phase_q, phase_d;
  logic [7:0]            led_q, led_d;
  logic                  tick;
  logic                  mode_chg;

  // Debounce: a level change is accepted after DEBOUNCE_CYCLES differing samples;
  // only a rising accepted level yields a press pulse.
  always_comb begin
    db_lvl_d = db_lvl_q;
    db_cnt_d = '0;
    press_d  = '0;
    for (int i = 0; i < 4; i++) begin
      if (btn_s_q[i] != db_lvl_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          db_lvl_d[i] = btn_s_q[i];
          press_d[i]  = btn_s_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Mode, pause, prescaler and pattern next-state; mode change beats load beats tick.
  always_comb begin
    tick      = (ps_q == PsLast) && !paused_q;
    mode_chg  = press_q[BtnNext] ^ press_q[BtnPrev];
    mode_d    = mode_q;
    ps_d      = ps_q;
    paused_d  = paused_q;
    phase_d   = phase_q;
    pattern_d = pattern_q;

    if (press_q[BtnNext] && !press_q[BtnPrev]) begin
      mode_d = mode_e'(mode_q + 2'd1);
    end else if (press_q[BtnPrev] && !press_q[BtnNext]) begin
      mode_d = mode_e'(mode_q - 2'd1);
    end

    if (mode_chg) begin
      ps_d     = '0;
      paused_d = 1'b0;
      phase_d  = 1'b1;
      case (mode_d)
        ModeCount: pattern_d = 8'h00;
        ModeShift: pattern_d = 8'h01;
        ModeBlink: pattern_d = sw_s_q;
        default:   pattern_d = pattern_q;
      endcase
    end else begin
      if (press_q[BtnPause]) begin
        paused_d = !paused_q;
      end
      if (!paused_q) begin
        ps_d = (ps_q == PsLast) ? '0 : ps_q + 1'b1;
      end
      if (press_q[BtnLoad] && (mode_q != ModeMirror)) begin
        pattern_d = sw_s_q;
      end else if (tick) begin
        case (mode_q)
          ModeCount: pattern_d = pattern_q + 8'd1;
          ModeShift: pattern_d = {pattern_q[6:0], pattern_q[7]};
          default:   pattern_d = pattern_q;
        endcase
      end
      // Blink phase runs off the tick independently of pattern loads.
      if (tick && (mode_q == ModeBlink)) begin
        phase_d = !phase_q;
      end
    end
  end

  // LED drive from the registered state, so it trails the pattern by one cycle.
  always_comb begin
    case (mode_q)
      ModeMirror: led_d = sw_s_q;
      ModeBlink:  led_d = phase_q ? pattern_q : 8'h00;
      default:    led_d = pattern_q;
    endcase
  end

  // All state, including the input synchronizers, with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta_q  <= '0;
      sw_s_q     <= '0;
      btn_meta_q <= '0;
      btn_s_q    <= '0;
      db_lvl_q   <= '0;
      db_cnt_q   <= '0;
      press_q    <= '0;
      mode_q     <= ModeMirror;
      pattern_q  <= '0;
      ps_q       <= '0;
      paused_q   <= 1'b0;
      phase_q    <= 1'b0;
      led_q      <= '0;
    end else begin
      sw_meta_q  <= switch;
      sw_s_q     <= sw_meta_q;
      btn_meta_q <= push_btn;
      btn_s_q    <= btn_meta_q;
      db_lvl_q   <= db_lvl_d;
      db_cnt_q   <= db_cnt_d;
      press_q    <= press_d;
      mode_q     <= mode_d;
      pattern_q  <= pattern_d;
      ps_q       <= ps_d;
      paused_q   <= paused_d;
      phase_q    <= phase_d;
      led_q      <= led_d;
    end
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Randomized and directed bench for led_mode_sequencer against a behavioural model.
module tb_led_mode_sequencer;

  localparam int TickDiv = 4;
  localparam int DbCyc   = 3;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw;
  logic [3:0] btn;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;

  led_mode_sequencer #(
    .TICK_DIV       (TickDiv),
    .DEBOUNCE_CYCLES(DbCyc)
  ) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .switch  (sw),
    .push_btn(btn),
    .led     (led),
    .mode    (mode),
    .paused  (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state: delay lines, run-length debouncers, display state.
  int m_sw1, m_sw2;
  int m_bt1 [4];
  int m_bt2 [4];
  int m_lvl [4];
  int m_run [4];
  bit m_pulse [4];
  int m_mode, m_pat, m_ps, m_led;
  bit m_pause, m_phase;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 8'h%02h, expected 8'h%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sw1 = 0; m_sw2 = 0;
    for (int i = 0; i < 4; i++) begin
      m_bt1[i] = 0; m_bt2[i] = 0; m_lvl[i] = 0; m_run[i] = 0; m_pulse[i] = 0;
    end
    m_mode = 0; m_pat = 0; m_ps = 0; m_led = 0; m_pause = 0; m_phase = 0;
  endtask

  // One clock edge of the reference; later stages are evaluated first so each
  // sees the values from before the edge.
  task automatic model_step();
    int  nxt;
    bit  tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_mode == 0)      m_led = m_sw2;
    else if (m_mode == 3) m_led = m_phase ? m_pat : 0;
    else                  m_led = m_pat;

    tk  = (m_ps == TickDiv - 1) && !m_pause;
    nxt = m_mode;
    if (m_pulse[0] != m_pulse[1]) nxt = (m_mode + (m_pulse[0] ? 1 : 3)) % 4;
    if (nxt != m_mode) begin
      m_ps = 0; m_pause = 0; m_phase = 1;
      if (nxt == 1)      m_pat = 0;
      else if (nxt == 2) m_pat = 1;
      else if (nxt == 3) m_pat = m_sw2;
    end else begin
      if (m_pulse[3] && m_mode != 0)  m_pat = m_sw2;
      else if (tk && m_mode == 1)     m_pat = (m_pat + 1) % 256;
      else if (tk && m_mode == 2)     m_pat = ((m_pat * 2) % 256) + (m_pat / 128);
      if (tk && m_mode == 3) m_phase = !m_phase;
      if (!m_pause) m_ps = (m_ps + 1) % TickDiv;
      if (m_pulse[2]) m_pause = !m_pause;
    end
    m_mode = nxt;

    for (int i = 0; i < 4; i++) begin
      m_pulse[i] = 0;
      if (m_bt2[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DbCyc) begin
          m_lvl[i]   = m_bt2[i];
          m_run[i]   = 0;
          m_pulse[i] = (m_lvl[i] == 1);
        end
      end else begin
        m_run[i] = 0;
      end
    end

    for (int i = 0; i < 4; i++) begin
      m_bt2[i] = m_bt1[i];
      m_bt1[i] = int'(btn[i]);
    end
    m_sw2 = m_sw1;
    m_sw1 = int'(sw);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_eq("led", led, 8'(m_led));
    check_eq("mode", {6'b0, mode}, 8'(m_mode));
    check_eq("paused", {7'b0, paused}, {7'b0, m_pause});
  endtask

  task automatic press(input logic [3:0] which, input int hold, input int after);
    btn = which;
    repeat (hold) step();
    btn = 4'b0000;
    repeat (after) step();
  endtask

  int n_on, n_off;
  bit found;
  logic [7:0] frozen;
  logic [7:0] pat_v;

  initial begin
    rst_n = 1'b0;
    sw    = 8'h00;
    btn   = 4'b0000;
    model_reset();
    repeat (3) step();
    check_eq("reset_led", led, 8'h00);
    check_eq("reset_mode", {6'b0, mode}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Mirror sweep.
    for (int v = 0; v < 256; v++) begin
      sw = 8'(v);
      repeat (3) step();
      check_eq("mirror_lat3", led, 8'(v));
      repeat (17) step();
    end

    // Count mode including a full wrap.
    press(4'b0001, 10, 4);
    check_eq("enter_count", {6'b0, mode}, 8'h01);
    repeat (256 * TickDiv + 20) step();

    // Glitch rejection and mode navigation.
    press(4'b0001, 2, 10);
    check_eq("glitch_ignored", {6'b0, mode}, 8'h01);
    press(4'b0010, 10, 4);
    check_eq("prev_to_mirror", {6'b0, mode}, 8'h00);
    press(4'b0010, 10, 4);
    check_eq("prev_wrap_blink", {6'b0, mode}, 8'h03);
    press(4'b0011, 10, 4);
    check_eq("both_no_change", {6'b0, mode}, 8'h03);
    press(4'b0010, 10, 4);
    check_eq("prev_to_shift", {6'b0, mode}, 8'h02);

    // Shift with pause and resume.
    repeat (40) step();
    press(4'b0100, 6, 2);
    check_eq("pause_on", {7'b0, paused}, 8'h01);
    frozen = 8'(m_led);
    for (int k = 0; k < 40; k++) begin
      step();
      check_eq("frozen", led, frozen);
    end
    press(4'b0100, 6, 2);
    check_eq("pause_off", {7'b0, paused}, 8'h00);
    repeat (40) step();

    // Blink with switch-seeded and loaded patterns.
    sw = 8'hA5;
    repeat (5) step();
    press(4'b0001, 10, 4);
    check_eq("enter_blink", {6'b0, mode}, 8'h03);
    n_on = 0; n_off = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (led == 8'hA5) n_on++;
      if (led == 8'h00) n_off++;
    end
    check_eq("blink_a5_on", 8'(n_on), 8'd8);
    check_eq("blink_a5_off", 8'(n_off), 8'd8);
    sw = 8'h3C;
    repeat (3) step();
    press(4'b1000, 6, 6);
    n_on = 0; n_off = 0;
    for (int k = 0; k < 16; k++) begin
      step();
      if (led == 8'h3C) n_on++;
      if (led == 8'h00) n_off++;
    end
    check_eq("blink_3c_on", 8'(n_on), 8'd8);
    check_eq("blink_3c_off", 8'(n_off), 8'd8);
    press(4'b0001, 10, 4);
    check_eq("blink_to_mirror", {6'b0, mode}, 8'h00);
    pat_v = 8'(m_pat);
    sw = 8'h77;
    press(4'b1000, 6, 6);
    check_eq("load_in_mirror", 8'(m_pat), pat_v);
    check_eq("mirror_after_load", led, 8'h77);

    // Asynchronous reset mid-count.
    press(4'b0001, 10, 4);
    check_eq("enter_count2", {6'b0, mode}, 8'h01);
    found = 1'b0;
    for (int k = 0; k < 600 && !found; k++) begin
      step();
      if (led == 8'h17) found = 1'b1;
    end
    check_eq("reach_17", {7'b0, found}, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_led", led, 8'h00);
    check_eq("async_rst_mode", {6'b0, mode}, 8'h00);
    model_reset();
    repeat (3) step();
    sw = 8'h5A;
    rst_n = 1'b1;
    repeat (3) step();
    check_eq("resume_mirror", led, 8'h5A);

    // Randomized traffic.
    for (int it = 0; it < 1500; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          sw = 8'($urandom);
          repeat ($urandom_range(1, 8)) step();
        end
        8: repeat (20) step();
        9: press(4'($urandom), $urandom_range(1, 8), $urandom_range(0, 12));
        default: press(4'(1 << $urandom_range(0, 3)), $urandom_range(1, 8),
                       $urandom_range(0, 12));
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
